ccr_unit: RTL and testbench

Condition-code register for the core's execute stage. It stores the 4-bit flags produced by the ALU and feeds them back as the ALU's `flags_in`. It evaluates conditional-jump conditions and clears the tested flag when a conditional jump is taken. It also saves and restores the flags on interrupt entry (save) and RTI (restore) through a small LIFO shadow stack.

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/flag_stack.sv | 59 +++++
 rtl/ccr_unit.sv | 125 ++++++++++++
 tb/tb_ccr_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the condition-code register: flag bit positions
// and jump-condition encodings.
package cmp_pkg;

    localparam int FLAG_W = 4;

    // Flag bit positions within the flag word.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Jump-condition encodings carried on jmp_cond.
    typedef enum logic [1:0] {
        JC_Z      = 2'b00,
        JC_N      = 2'b01,
        JC_C      = 2'b10,
        JC_ALWAYS = 2'b11
    } jmp_cond_e;

endpackage : cmp_pkg

// File: rtl/flag_stack.sv
// LIFO shadow stack holding saved flag words across nested interrupts.
// A pop takes precedence over a push in the same cycle; pushes to a full
// stack and pops from an empty stack are ignored.
module flag_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_m1;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          pop_ok;
    logic          push_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && !full && !pop_ok;
    assign count_m1 = count_q - CW'(1);
    assign wr_idx   = count_q[AW-1:0];
    assign rd_idx   = count_m1[AW-1:0];
    assign top_data = mem[rd_idx];
    assign count    = count_q;

    // Occupancy counter: up on push, down on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else if (pop_ok) begin
            count_q <= count_m1;
        end else if (push_ok) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Entry storage written at the current top on a push.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries above count are never read, so a reset would only add logic.
        if (push_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule : flag_stack

// File: rtl/ccr_unit.sv
// Condition-code register for the execute stage: holds the ALU flags,
// evaluates conditional jumps, and saves/restores flags across interrupts.
module ccr_unit
    import cmp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = cmp_pkg::FLAG_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [FLAG_W-1:0]            alu_flags,
    input  logic                         alu_we,
    input  logic [FLAG_W-1:0]            flag_mask,
    input  logic                         setc,
    input  logic                         clrc,
    input  logic                         jmp_valid,
    input  logic [1:0]                   jmp_cond,
    input  logic                         int_save,
    input  logic                         int_restore,
    output logic [FLAG_W-1:0]            flags_out,
    output logic                         jmp_taken,
    output logic [$clog2(DEPTH+1)-1:0]   stack_cnt,
    output logic                         stack_ovf,
    output logic                         stack_unf
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] tested_bit;
    logic [FLAG_W-1:0] pop_data;
    logic              cond_hit;
    logic              st_full;
    logic              st_empty;
    logic              do_pop;
    logic              do_push;
    logic              ovf_q;
    logic              unf_q;

    // A restore wins over a simultaneous save; the save is silently dropped.
    assign do_pop  = int_restore && !st_empty;
    assign do_push = int_save && !int_restore;

    flag_stack #(
        .DEPTH (DEPTH),
        .W     (FLAG_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (flags_q),
        .top_data  (pop_data),
        .count     (stack_cnt),
        .full      (st_full),
        .empty     (st_empty)
    );

    // Jump decision from the registered flags, plus the bit a taken jump clears.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cond_hit   = 1'b0;
        tested_bit = '0;
        unique case (jmp_cond_e'(jmp_cond))
            JC_Z: begin
                cond_hit           = flags_q[FLAG_Z];
                tested_bit[FLAG_Z] = 1'b1;
            end
            JC_N: begin
                cond_hit           = flags_q[FLAG_N];
                tested_bit[FLAG_N] = 1'b1;
            end
            JC_C: begin
                cond_hit           = flags_q[FLAG_C];
                tested_bit[FLAG_C] = 1'b1;
            end
            JC_ALWAYS: begin
                cond_hit = 1'b1;
            end
            default: ;
        endcase
        jmp_taken = jmp_valid && cond_hit;
    end

    // Next-flag priority chain, later steps override earlier ones.
    always_comb begin
        flags_d = flags_q;
        if (alu_we) begin
            flags_d = (flags_d & ~flag_mask) | (alu_flags & flag_mask);
        end
        if (jmp_taken) begin
            flags_d = flags_d & ~tested_bit;
        end
        if (setc) begin
            flags_d[FLAG_C] = 1'b1;
        end
        if (clrc) begin
            flags_d[FLAG_C] = 1'b0;
        end
        if (do_pop) begin
            flags_d = pop_data;
        end
    end

    // Flag register and sticky stack error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            if (do_push && st_full) begin
                ovf_q <= 1'b1;
            end
            if (int_restore && st_empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign flags_out = flags_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule : ccr_unit

// File: tb/tb_ccr_unit.sv
// Directed self-checking bench for ccr_unit.
module tb_ccr_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] alu_flags;
    logic       alu_we;
    logic [3:0] flag_mask;
    logic       setc;
    logic       clrc;
    logic       jmp_valid;
    logic [1:0] jmp_cond;
    logic       int_save;
    logic       int_restore;
    logic [3:0] flags_out;
    logic       jmp_taken;
    logic [2:0] stack_cnt;
    logic       stack_ovf;
    logic       stack_unf;

    int passed;
    int total;

    ccr_unit #(.DEPTH(4), .FLAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_flags   (alu_flags),
        .alu_we      (alu_we),
        .flag_mask   (flag_mask),
        .setc        (setc),
        .clrc        (clrc),
        .jmp_valid   (jmp_valid),
        .jmp_cond    (jmp_cond),
        .int_save    (int_save),
        .int_restore (int_restore),
        .flags_out   (flags_out),
        .jmp_taken   (jmp_taken),
        .stack_cnt   (stack_cnt),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        alu_flags   = 4'b0000;
        alu_we      = 1'b0;
        flag_mask   = 4'b0000;
        setc        = 1'b0;
        clrc        = 1'b0;
        jmp_valid   = 1'b0;
        jmp_cond    = 2'b00;
        int_save    = 1'b0;
        int_restore = 1'b0;
    endtask

    // Advance past one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] v);
        idle();
        alu_we    = 1'b1;
        flag_mask = 4'b1111;
        alu_flags = v;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        total++;
        if (flags_out !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags_out);
        else passed++;
        total++;
        if (stack_cnt !== 3'd0) $display("FAIL reset_cnt got=%0d exp=0", stack_cnt);
        else passed++;
        total++;
        if ({stack_ovf, stack_unf} !== 2'b00) $display("FAIL reset_err got=%b exp=00", {stack_ovf, stack_unf});
        else passed++;
        #9;
        rst_n = 1'b1;
    endtask

    task automatic test_masked_write();
        load_flags(4'b0100);
        alu_we = 1'b1; alu_flags = 4'b0011; flag_mask = 4'b0011;
        step();
        total++;
        if (flags_out !== 4'b0111) $display("FAIL masked_write got=%b exp=0111", flags_out);
        else passed++;
        load_flags(4'b0100);
        alu_we = 1'b1; alu_flags = 4'b1111; flag_mask = 4'b0000;
        step();
        total++;
        if (flags_out !== 4'b0100) $display("FAIL zero_mask got=%b exp=0100", flags_out);
        else passed++;
        idle();
    endtask

    task automatic test_jumps();
        // JZ with Z=1: taken now, Z cleared after the edge.
        load_flags(4'b0001);
        jmp_valid = 1'b1; jmp_cond = 2'b00;
        #1;
        total++;
        if (jmp_taken !== 1'b1) $display("FAIL jz_taken got=%b exp=1", jmp_taken);
        else passed++;
        step();
        total++;
        if (flags_out !== 4'b0000) $display("FAIL jz_clear got=%b exp=0000", flags_out);
        else passed++;
        // JN with N=0: not taken, flags unchanged.
        load_flags(4'b1101);
        jmp_valid = 1'b1; jmp_cond = 2'b01;
        #1;
        total++;
        if (jmp_taken !== 1'b0) $display("FAIL jn_not_taken got=%b exp=0", jmp_taken);
        else passed++;
        step();
        total++;
        if (flags_out !== 4'b1101) $display("FAIL jn_hold got=%b exp=1101", flags_out);
        else passed++;
        // JMP: always taken, flags unchanged.
        jmp_cond = 2'b11;
        #1;
        total++;
        if (jmp_taken !== 1'b1) $display("FAIL jmp_taken got=%b exp=1", jmp_taken);
        else passed++;
        step();
        total++;
        if (flags_out !== 4'b1101) $display("FAIL jmp_hold got=%b exp=1101", flags_out);
        else passed++;
        // JC with C=1: taken, C cleared.
        jmp_cond = 2'b10;
        #1;
        total++;
        if (jmp_taken !== 1'b1) $display("FAIL jc_taken got=%b exp=1", jmp_taken);
        else passed++;
        step();
        total++;
        if (flags_out !== 4'b1001) $display("FAIL jc_clear got=%b exp=1001", flags_out);
        else passed++;
        // No valid jump: never taken even when Z=1.
        jmp_valid = 1'b0; jmp_cond = 2'b11;
        #1;
        total++;
        if (jmp_taken !== 1'b0) $display("FAIL jmp_invalid got=%b exp=0", jmp_taken);
        else passed++;
        idle();
    endtask

    task automatic test_simultaneous();
        load_flags(4'b0000);
        alu_we = 1'b1; flag_mask = 4'b0100; alu_flags = 4'b0100; clrc = 1'b1;
        step();
        total++;
        if (flags_out !== 4'b0000) $display("FAIL alu_vs_clrc got=%b exp=0000", flags_out);
        else passed++;
        idle();
        setc = 1'b1;
        step();
        total++;
        if (flags_out !== 4'b0100) $display("FAIL setc got=%b exp=0100", flags_out);
        else passed++;
        idle();
        setc = 1'b1; clrc = 1'b1;
        step();
        total++;
        if (flags_out !== 4'b0000) $display("FAIL setc_clrc got=%b exp=0000", flags_out);
        else passed++;
        idle();
        alu_we = 1'b1; flag_mask = 4'b1111; alu_flags = 4'b0000; setc = 1'b1;
        step();
        total++;
        if (flags_out !== 4'b0100) $display("FAIL alu_vs_setc got=%b exp=0100", flags_out);
        else passed++;
        idle();
    endtask

    task automatic test_collision();
        load_flags(4'b0110);
        int_save = 1'b1;
        step();
        idle();
        load_flags(4'b1001);
        int_save = 1'b1; int_restore = 1'b1;
        alu_we = 1'b1; flag_mask = 4'b1111; alu_flags = 4'b1111;
        step();
        total++;
        if (stack_cnt !== 3'd0) $display("FAIL collide_cnt got=%0d exp=0", stack_cnt);
        else passed++;
        total++;
        if (flags_out !== 4'b0110) $display("FAIL collide_flags got=%b exp=0110", flags_out);
        else passed++;
        total++;
        if ({stack_ovf, stack_unf} !== 2'b00) $display("FAIL collide_err got=%b exp=00", {stack_ovf, stack_unf});
        else passed++;
        idle();
    endtask

    task automatic test_nested();
        logic [3:0] pushed [4];
        logic [3:0] nxt [4];
        pushed[0] = 4'b0001; pushed[1] = 4'b0010; pushed[2] = 4'b0100; pushed[3] = 4'b1000;
        nxt[0] = 4'b0010; nxt[1] = 4'b0100; nxt[2] = 4'b1000; nxt[3] = 4'b1111;
        load_flags(4'b0001);
        // Each save pushes the pre-update flags while the ALU write still lands.
        for (int i = 0; i < 4; i++) begin
            idle();
            int_save = 1'b1;
            alu_we = 1'b1; flag_mask = 4'b1111; alu_flags = nxt[i];
            step();
            total++;
            if (stack_cnt !== 3'(i + 1)) $display("FAIL push_cnt%0d got=%0d exp=%0d", i, stack_cnt, i + 1);
            else passed++;
        end
        idle();
        int_save = 1'b1;
        step();
        total++;
        if (stack_ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", stack_ovf);
        else passed++;
        total++;
        if (stack_cnt !== 3'd4) $display("FAIL ovf_cnt got=%0d exp=4", stack_cnt);
        else passed++;
        total++;
        if (flags_out !== 4'b1111) $display("FAIL ovf_flags got=%b exp=1111", flags_out);
        else passed++;
        // Restores override a concurrent ALU write and setc.
        for (int i = 3; i >= 0; i--) begin
            idle();
            int_restore = 1'b1;
            alu_we = 1'b1; flag_mask = 4'b1111; alu_flags = 4'b0000; setc = 1'b1;
            step();
            total++;
            if (flags_out !== pushed[i]) $display("FAIL pop_flags%0d got=%b exp=%b", i, flags_out, pushed[i]);
            else passed++;
            total++;
            if (stack_cnt !== 3'(i)) $display("FAIL pop_cnt%0d got=%0d exp=%0d", i, stack_cnt, i);
            else passed++;
        end
        total++;
        if ({stack_ovf, stack_unf} !== 2'b10) $display("FAIL ovf_sticky got=%b exp=10", {stack_ovf, stack_unf});
        else passed++;
        idle();
    endtask

    task automatic test_underflow();
        int_restore = 1'b1;
        alu_we = 1'b1; flag_mask = 4'b1111; alu_flags = 4'b1010;
        step();
        total++;
        if (stack_unf !== 1'b1) $display("FAIL unf_set got=%b exp=1", stack_unf);
        else passed++;
        total++;
        if (flags_out !== 4'b1010) $display("FAIL unf_flags got=%b exp=1010", flags_out);
        else passed++;
        total++;
        if (stack_cnt !== 3'd0) $display("FAIL unf_cnt got=%0d exp=0", stack_cnt);
        else passed++;
        idle();
    endtask

    task automatic test_reset_mid();
        load_flags(4'b1111);
        int_save = 1'b1;
        step();
        step();
        idle();
        total++;
        if (stack_cnt !== 3'd2) $display("FAIL pre_reset_cnt got=%0d exp=2", stack_cnt);
        else passed++;
        // Drop reset between edges, in the middle of a push.
        int_save = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (flags_out !== 4'b0000) $display("FAIL midrst_flags got=%b exp=0000", flags_out);
        else passed++;
        total++;
        if (stack_cnt !== 3'd0) $display("FAIL midrst_cnt got=%0d exp=0", stack_cnt);
        else passed++;
        total++;
        if ({stack_ovf, stack_unf} !== 2'b00) $display("FAIL midrst_err got=%b exp=00", {stack_ovf, stack_unf});
        else passed++;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        // First edge after reset release behaves normally.
        alu_we = 1'b1; flag_mask = 4'b1111; alu_flags = 4'b0011;
        step();
        total++;
        if (flags_out !== 4'b0011) $display("FAIL post_rst_write got=%b exp=0011", flags_out);
        else passed++;
        // Push then pop on consecutive cycles.
        idle();
        int_save = 1'b1;
        alu_we = 1'b1; flag_mask = 4'b1111; alu_flags = 4'b1100;
        step();
        idle();
        int_restore = 1'b1;
        step();
        total++;
        if (flags_out !== 4'b0011) $display("FAIL b2b_pop got=%b exp=0011", flags_out);
        else passed++;
        total++;
        if (stack_cnt !== 3'd0) $display("FAIL b2b_cnt got=%0d exp=0", stack_cnt);
        else passed++;
        idle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_masked_write();
        test_jumps();
        test_simultaneous();
        test_collision();
        test_nested();
        test_underflow();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_ccr_unit
